// File: rtl/vliw_pkg.sv
// Shared types for the VLIW decode/issue stage.
// Operation classes, register-field offsets and per-slot control bundle.
package vliw_pkg;

    typedef enum logic [1:0] {
        CLS_NOP   = 2'b00,
        CLS_ALU   = 2'b01,
        CLS_LOAD  = 2'b10,
        CLS_STORE = 2'b11
    } cls_e;

    // Register fields, counted in REG_AW units down from the instruction MSB
    localparam int RS1_FLD = 0;
    localparam int RS2_FLD = 1;
    localparam int RD_FLD  = 2;
    localparam int CLS_W   = 2;

    typedef struct packed {
        logic use_rs1;
        logic use_rs2;
        logic reg_write;
        logic mem_read;
        logic mem_write;
    } slot_ctrl_t;

    function automatic slot_ctrl_t decode_slot(input logic v, input logic [CLS_W-1:0] cls);
        slot_ctrl_t c;
        c = '0;
        if (v) begin
            case (cls_e'(cls))
                CLS_ALU:   begin c.use_rs1 = 1'b1; c.use_rs2 = 1'b1; c.reg_write = 1'b1; end
                CLS_LOAD:  begin c.use_rs1 = 1'b1; c.reg_write = 1'b1; c.mem_read = 1'b1; end
                CLS_STORE: begin c.use_rs1 = 1'b1; c.use_rs2 = 1'b1; c.mem_write = 1'b1; end
                default:   c = '0;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/id_issue_stage_if.sv
// ID-stage bundle: IF/ID inputs, write-back ports, ID/EX control and outputs.
interface id_issue_stage_if #(
    parameter int NUM_SLOTS = 2,
    parameter int INSTR_W   = 16,
    parameter int DATA_W    = 32,
    parameter int NUM_REGS  = 8
);
    localparam int REG_AW = $clog2(NUM_REGS);

    logic [NUM_SLOTS-1:0]           id_valid;
    logic [NUM_SLOTS*INSTR_W-1:0]   id_instr;
    logic [NUM_SLOTS-1:0]           wb_we;
    logic [NUM_SLOTS*REG_AW-1:0]    wb_addr;
    logic [NUM_SLOTS*DATA_W-1:0]    wb_data;
    logic                           ex_en;
    logic                           ex_flush;
    logic                           stall_o;
    logic [NUM_SLOTS-1:0]           ex_valid;
    logic [NUM_SLOTS-1:0]           ex_reg_write;
    logic [NUM_SLOTS-1:0]           ex_mem_read;
    logic [NUM_SLOTS-1:0]           ex_mem_write;
    logic [NUM_SLOTS*INSTR_W-1:0]   ex_instr;
    logic [NUM_SLOTS*REG_AW-1:0]    ex_rs1;
    logic [NUM_SLOTS*REG_AW-1:0]    ex_rs2;
    logic [NUM_SLOTS*REG_AW-1:0]    ex_rd;
    logic [NUM_SLOTS*DATA_W-1:0]    ex_rs1_val;
    logic [NUM_SLOTS*DATA_W-1:0]    ex_rs2_val;

    modport master (
        output id_valid, id_instr, wb_we, wb_addr, wb_data, ex_en, ex_flush,
        input  stall_o, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write,
        input  ex_instr, ex_rs1, ex_rs2, ex_rd, ex_rs1_val, ex_rs2_val
    );

    modport slave (
        input  id_valid, id_instr, wb_we, wb_addr, wb_data, ex_en, ex_flush,
        output stall_o, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write,
        output ex_instr, ex_rs1, ex_rs2, ex_rd, ex_rs1_val, ex_rs2_val
    );

endinterface

// File: rtl/vliw_regfile.sv
// Multiport register file: priority write (highest port wins) and
// same-cycle write-to-read bypass.
module vliw_regfile #(
    parameter int NUM_RD   = 4,
    parameter int NUM_WR   = 2,
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 8,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*AW-1:0]     raddr_i,
    output logic [NUM_RD*DATA_W-1:0] rdata_o,
    input  logic [NUM_WR-1:0]        we_i,
    input  logic [NUM_WR*AW-1:0]     waddr_i,
    input  logic [NUM_WR*DATA_W-1:0] wdata_i
);

    logic [DATA_W-1:0] mem_q [NUM_REGS];
    logic [DATA_W-1:0] mem_d [NUM_REGS];

    always_comb begin
        mem_d = mem_q;
        for (int w = 0; w < NUM_WR; w++) begin
            if (we_i[w]) mem_d[waddr_i[w*AW +: AW]] = wdata_i[w*DATA_W +: DATA_W];
        end
    end

    // Later ports override earlier ones, giving highest-slot priority
    always_comb begin
        rdata_o = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            rdata_o[r*DATA_W +: DATA_W] = mem_q[raddr_i[r*AW +: AW]];
            for (int w = 0; w < NUM_WR; w++) begin
                if (we_i[w] && waddr_i[w*AW +: AW] == raddr_i[r*AW +: AW])
                    rdata_o[r*DATA_W +: DATA_W] = wdata_i[w*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) mem_q <= '{default: '0};
        else       mem_q <= mem_d;
    end

endmodule

// File: rtl/id_issue_stage.sv
// VLIW decode/register-read stage: field extract, regfile read with bypass,
// load-use hazard detect and the ID/EX pipeline register.
module id_issue_stage
    import vliw_pkg::*;
#(
    parameter int NUM_SLOTS = 2,
    parameter int INSTR_W   = 16,
    parameter int DATA_W    = 32,
    parameter int NUM_REGS  = 8
) (
    input  logic         clk,
    input  logic         reset,
    id_issue_stage_if.slave bus
);

    localparam int REG_AW = $clog2(NUM_REGS);
    localparam int NRP    = 2 * NUM_SLOTS;

    logic [NRP*REG_AW-1:0]               raddr;
    logic [NRP*DATA_W-1:0]               rdata;
    logic [NUM_SLOTS-1:0][REG_AW-1:0]    rs1, rs2, rd;
    slot_ctrl_t [NUM_SLOTS-1:0]          ctrl;
    logic                                haz;

    logic [NUM_SLOTS-1:0]                valid_d, valid_q;
    logic [NUM_SLOTS-1:0]                rw_d, rw_q;
    logic [NUM_SLOTS-1:0]                mr_d, mr_q;
    logic [NUM_SLOTS-1:0]                mw_d, mw_q;
    logic [NUM_SLOTS*INSTR_W-1:0]        instr_d, instr_q;
    logic [NUM_SLOTS-1:0][REG_AW-1:0]    rs1_d, rs1_q, rs2_d, rs2_q, rd_d, rd_q;
    logic [NUM_SLOTS*DATA_W-1:0]         v1_d, v1_q, v2_d, v2_q;
    logic [NUM_SLOTS*DATA_W-1:0]         v1_rd, v2_rd;

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_dec
        logic [INSTR_W-1:0] ins;
        assign ins    = bus.id_instr[i*INSTR_W +: INSTR_W];
        assign rs1[i] = ins[INSTR_W-1-RS1_FLD*REG_AW -: REG_AW];
        assign rs2[i] = ins[INSTR_W-1-RS2_FLD*REG_AW -: REG_AW];
        assign rd[i]  = ins[INSTR_W-1-RD_FLD*REG_AW -: REG_AW];
        assign ctrl[i] = decode_slot(bus.id_valid[i], ins[CLS_W-1:0]);
        assign raddr[(2*i)*REG_AW +: REG_AW]   = rs1[i];
        assign raddr[(2*i+1)*REG_AW +: REG_AW] = rs2[i];
        assign v1_rd[i*DATA_W +: DATA_W] = rdata[(2*i)*DATA_W +: DATA_W];
        assign v2_rd[i*DATA_W +: DATA_W] = rdata[(2*i+1)*DATA_W +: DATA_W];
    end

    vliw_regfile #(
        .NUM_RD   (NRP),
        .NUM_WR   (NUM_SLOTS),
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_rf (
        .clk     (clk),
        .reset   (reset),
        .raddr_i (raddr),
        .rdata_o (rdata),
        .we_i    (bus.wb_we),
        .waddr_i (bus.wb_addr),
        .wdata_i (bus.wb_data)
    );

    always_comb begin
        haz = 1'b0;
        for (int j = 0; j < NUM_SLOTS; j++) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (valid_q[j] && mr_q[j] &&
                    ((ctrl[i].use_rs1 && rd_q[j] == rs1[i]) ||
                     (ctrl[i].use_rs2 && rd_q[j] == rs2[i])))
                    haz = 1'b1;
            end
        end
    end

    always_comb begin
        valid_d = bus.id_valid;
        instr_d = bus.id_instr;
        rs1_d   = rs1;
        rs2_d   = rs2;
        rd_d    = rd;
        v1_d    = v1_rd;
        v2_d    = v2_rd;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            rw_d[i] = ctrl[i].reg_write;
            mr_d[i] = ctrl[i].mem_read;
            mw_d[i] = ctrl[i].mem_write;
        end
        if (bus.ex_flush || haz) begin
            valid_d = '0; rw_d = '0; mr_d = '0; mw_d = '0;
            instr_d = '0; rs1_d = '0; rs2_d = '0; rd_d = '0;
            v1_d = '0; v2_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0; rw_q <= '0; mr_q <= '0; mw_q <= '0;
            instr_q <= '0; rs1_q <= '0; rs2_q <= '0; rd_q <= '0;
            v1_q <= '0; v2_q <= '0;
        end else if (bus.ex_en) begin
            valid_q <= valid_d; rw_q <= rw_d; mr_q <= mr_d; mw_q <= mw_d;
            instr_q <= instr_d; rs1_q <= rs1_d; rs2_q <= rs2_d; rd_q <= rd_d;
            v1_q <= v1_d; v2_q <= v2_d;
        end
    end

    assign bus.stall_o      = haz;
    assign bus.ex_valid     = valid_q;
    assign bus.ex_reg_write = rw_q;
    assign bus.ex_mem_read  = mr_q;
    assign bus.ex_mem_write = mw_q;
    assign bus.ex_instr     = instr_q;
    assign bus.ex_rs1       = rs1_q;
    assign bus.ex_rs2       = rs2_q;
    assign bus.ex_rd        = rd_q;
    assign bus.ex_rs1_val   = v1_q;
    assign bus.ex_rs2_val   = v2_q;

endmodule

// File: tb/tb_id_issue_stage.sv
// Directed testbench for id_issue_stage (2 slots, 16-bit instr, 8 regs).
// Instruction layout: [15:13] rs1, [12:10] rs2, [9:7] rd, [1:0] cls.
module tb_id_issue_stage;

    localparam int NS = 2;
    localparam int IW = 16;
    localparam int DW = 32;
    localparam int NR = 8;

    localparam logic [1:0] NOP = 2'b00;
    localparam logic [1:0] ALU = 2'b01;
    localparam logic [1:0] LD  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    id_issue_stage_if #(.NUM_SLOTS(NS), .INSTR_W(IW), .DATA_W(DW), .NUM_REGS(NR)) bus ();

    id_issue_stage #(.NUM_SLOTS(NS), .INSTR_W(IW), .DATA_W(DW), .NUM_REGS(NR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    function automatic logic [15:0] mk(input int a, input int b, input int d, input logic [1:0] c);
        logic [2:0] a3, b3, d3;
        a3 = a[2:0]; b3 = b[2:0]; d3 = d[2:0];
        return {a3, b3, d3, 5'b0, c};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_wb();
        bus.wb_we   = '0;
        bus.wb_addr = '0;
        bus.wb_data = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.id_valid = 2'($urandom);
        bus.id_instr = 32'($urandom);
        bus.wb_we    = 2'($urandom);
        bus.wb_addr  = 6'($urandom);
        bus.wb_data  = {32'($urandom), 32'($urandom)};
        bus.ex_en    = 1'b1;
        bus.ex_flush = 1'($urandom);
        step();
        step();
        checks++;
        if (bus.ex_valid !== 2'b00) begin
            fails++; $display("FAIL reset_valid: got %b want 00", bus.ex_valid);
        end
        checks++;
        if ({bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write} !== 6'b0) begin
            fails++; $display("FAIL reset_ctrl: got %b want 0",
                              {bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write});
        end
        checks++;
        if ({bus.ex_instr, bus.ex_rs1_val, bus.ex_rs2_val} !== '0) begin
            fails++; $display("FAIL reset_data: instr %h rs1v %h", bus.ex_instr, bus.ex_rs1_val);
        end
        checks++;
        if (bus.stall_o !== 1'b0) begin
            fails++; $display("FAIL reset_stall: got %b want 0", bus.stall_o);
        end
        reset = 1'b0;
        bus.ex_flush = 1'b0;
        idle_wb();
        bus.id_valid = 2'b11;
        bus.id_instr = {mk(5, 6, 0, ALU), mk(1, 7, 2, ALU)};
        step();
        checks++;
        if ({bus.ex_rs1_val, bus.ex_rs2_val} !== '0) begin
            fails++; $display("FAIL reset_rf_read: rs1v %h rs2v %h want 0",
                              bus.ex_rs1_val, bus.ex_rs2_val);
        end
    endtask

    task automatic test_bypass();
        bus.wb_we   = 2'b01;
        bus.wb_addr = {3'd0, 3'd3};
        bus.wb_data = {32'h0, 32'hDEADBEEF};
        bus.id_valid = 2'b11;
        bus.id_instr = {mk(3, 0, 1, ALU), mk(0, 0, 0, NOP)};
        step();
        checks++;
        if (bus.ex_rs1_val[63:32] !== 32'hDEADBEEF) begin
            fails++; $display("FAIL bypass_val: got %h want deadbeef", bus.ex_rs1_val[63:32]);
        end
        checks++;
        if (bus.ex_valid !== 2'b11 || bus.ex_reg_write !== 2'b10) begin
            fails++; $display("FAIL bypass_ctrl: valid %b rw %b want 11 10",
                              bus.ex_valid, bus.ex_reg_write);
        end
        idle_wb();
        step();
        checks++;
        if (bus.ex_rs1_val[63:32] !== 32'hDEADBEEF) begin
            fails++; $display("FAIL stored_val: got %h want deadbeef", bus.ex_rs1_val[63:32]);
        end
    endtask

    task automatic test_conflict();
        bus.id_valid = 2'b00;
        bus.wb_we   = 2'b11;
        bus.wb_addr = {3'd5, 3'd5};
        bus.wb_data = {32'h22, 32'h11};
        step();
        idle_wb();
        bus.id_valid = 2'b01;
        bus.id_instr = {mk(0, 0, 0, NOP), mk(5, 5, 1, ALU)};
        step();
        checks++;
        if (bus.ex_rs1_val[31:0] !== 32'h22 || bus.ex_rs2_val[31:0] !== 32'h22) begin
            fails++; $display("FAIL conflict_store: rs1v %h rs2v %h want 22",
                              bus.ex_rs1_val[31:0], bus.ex_rs2_val[31:0]);
        end
        bus.wb_we   = 2'b11;
        bus.wb_addr = {3'd6, 3'd6};
        bus.wb_data = {32'h44, 32'h33};
        bus.id_instr = {mk(0, 0, 0, NOP), mk(6, 0, 1, ALU)};
        step();
        checks++;
        if (bus.ex_rs1_val[31:0] !== 32'h44) begin
            fails++; $display("FAIL conflict_bypass: got %h want 44", bus.ex_rs1_val[31:0]);
        end
        idle_wb();
    endtask

    task automatic test_load_use();
        bus.id_valid = 2'b01;
        bus.id_instr = {mk(0, 0, 0, NOP), mk(1, 0, 2, LD)};
        step();
        checks++;
        if (bus.ex_mem_read !== 2'b01 || bus.ex_rd[2:0] !== 3'd2) begin
            fails++; $display("FAIL lu_load: mr %b rd %0d want 01 2",
                              bus.ex_mem_read, bus.ex_rd[2:0]);
        end
        bus.id_valid = 2'b10;
        bus.id_instr = {mk(0, 2, 4, ALU), mk(0, 0, 0, NOP)};
        #1;
        checks++;
        if (bus.stall_o !== 1'b1) begin
            fails++; $display("FAIL lu_stall: got %b want 1", bus.stall_o);
        end
        step();
        checks++;
        if (bus.ex_valid !== 2'b00 || bus.stall_o !== 1'b0) begin
            fails++; $display("FAIL lu_bubble: valid %b stall %b want 00 0",
                              bus.ex_valid, bus.stall_o);
        end
        step();
        checks++;
        if (bus.ex_valid !== 2'b10 || bus.ex_reg_write !== 2'b10 || bus.ex_rd[5:3] !== 3'd4) begin
            fails++; $display("FAIL lu_capture: valid %b rw %b rd %0d want 10 10 4",
                              bus.ex_valid, bus.ex_reg_write, bus.ex_rd[5:3]);
        end
    endtask

    task automatic test_store_base();
        bus.id_valid = 2'b01;
        bus.id_instr = {mk(0, 0, 0, NOP), mk(0, 0, 4, LD)};
        step();
        bus.id_instr = {mk(0, 0, 0, NOP), mk(4, 4, 0, NOP)};
        #1;
        checks++;
        if (bus.stall_o !== 1'b0) begin
            fails++; $display("FAIL sb_nop: stall %b want 0", bus.stall_o);
        end
        bus.id_instr = {mk(0, 0, 0, NOP), mk(0, 4, 1, LD)};
        #1;
        checks++;
        if (bus.stall_o !== 1'b0) begin
            fails++; $display("FAIL sb_load_rs2: stall %b want 0", bus.stall_o);
        end
        bus.id_instr = {mk(4, 4, 1, ALU), mk(0, 0, 0, NOP)};
        #1;
        checks++;
        if (bus.stall_o !== 1'b0) begin
            fails++; $display("FAIL sb_invalid_slot: stall %b want 0", bus.stall_o);
        end
        bus.id_instr = {mk(0, 0, 0, NOP), mk(4, 0, 0, ST)};
        #1;
        checks++;
        if (bus.stall_o !== 1'b1) begin
            fails++; $display("FAIL sb_store_base: stall %b want 1", bus.stall_o);
        end
        bus.id_instr = {mk(0, 0, 0, NOP), mk(0, 0, 0, NOP)};
        step();
    endtask

    task automatic test_hold_flush();
        logic [31:0] exp_instr;
        exp_instr = {mk(0, 0, 0, NOP), mk(3, 0, 1, ALU)};
        bus.id_valid = 2'b01;
        bus.id_instr = exp_instr;
        step();
        checks++;
        if (bus.ex_valid !== 2'b01 || bus.ex_rs1_val[31:0] !== 32'hDEADBEEF) begin
            fails++; $display("FAIL hf_load: valid %b rs1v %h want 01 deadbeef",
                              bus.ex_valid, bus.ex_rs1_val[31:0]);
        end
        bus.ex_en    = 1'b0;
        bus.ex_flush = 1'b1;
        bus.id_valid = 2'b10;
        bus.id_instr = {mk(1, 2, 3, LD), mk(0, 0, 0, NOP)};
        step();
        checks++;
        if (bus.ex_valid !== 2'b01 || bus.ex_instr !== exp_instr ||
            bus.ex_rs1_val[31:0] !== 32'hDEADBEEF) begin
            fails++; $display("FAIL hf_hold: valid %b instr %h rs1v %h want 01 %h deadbeef",
                              bus.ex_valid, bus.ex_instr, bus.ex_rs1_val[31:0], exp_instr);
        end
        bus.ex_en = 1'b1;
        step();
        checks++;
        if (bus.ex_valid !== 2'b00 || bus.ex_mem_read !== 2'b00 ||
            bus.ex_instr !== '0 || bus.ex_rs1_val !== '0) begin
            fails++; $display("FAIL hf_flush: valid %b mr %b instr %h want 00 00 0",
                              bus.ex_valid, bus.ex_mem_read, bus.ex_instr);
        end
        bus.ex_flush = 1'b0;
    endtask

    task automatic test_reset_mid_stall();
        bus.id_valid = 2'b01;
        bus.id_instr = {mk(0, 0, 0, NOP), mk(0, 0, 6, LD)};
        step();
        bus.ex_en    = 1'b0;
        bus.id_instr = {mk(0, 0, 0, NOP), mk(6, 0, 1, ALU)};
        step();
        checks++;
        if (bus.stall_o !== 1'b1 || bus.ex_valid !== 2'b01 || bus.ex_mem_read !== 2'b01) begin
            fails++; $display("FAIL ms_hold: stall %b valid %b mr %b want 1 01 01",
                              bus.stall_o, bus.ex_valid, bus.ex_mem_read);
        end
        reset = 1'b1;
        step();
        checks++;
        if (bus.stall_o !== 1'b0 || bus.ex_valid !== 2'b00 || bus.ex_rd !== '0) begin
            fails++; $display("FAIL ms_reset: stall %b valid %b rd %h want 0 00 0",
                              bus.stall_o, bus.ex_valid, bus.ex_rd);
        end
        reset = 1'b0;
        bus.ex_en    = 1'b1;
        bus.id_instr = {mk(0, 0, 0, NOP), mk(3, 5, 1, ALU)};
        step();
        checks++;
        if (bus.ex_rs1_val[31:0] !== 32'h0 || bus.ex_rs2_val[31:0] !== 32'h0) begin
            fails++; $display("FAIL ms_rf_clear: rs1v %h rs2v %h want 0",
                              bus.ex_rs1_val[31:0], bus.ex_rs2_val[31:0]);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.id_valid = '0;
        bus.id_instr = '0;
        bus.ex_en    = 1'b0;
        bus.ex_flush = 1'b0;
        idle_wb();
        test_reset();
        test_bypass();
        test_conflict();
        test_load_use();
        test_store_base();
        test_hold_flush();
        test_reset_mid_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
